fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised SLC-3 instruction fetch engine. It owns PC, MAR, MDR and IR and runs the MAR<-PC / memory read / MDR<-rdata / IR<-MDR sequence against synchronous memory with a configurable read latency.
- Hands each instruction to decode over a valid/ready handshake.
- Supports PC redirect (branch/jump), run/pause/continue control, and a debug readout.
- Sits between the SLC-3 control/decode logic and the memory subsystem.

Parameters:
- DATA_WIDTH, 16, width of memory words, MDR and IR.
- ADDR_WIDTH, 16, width of PC, MAR and memory address.
- MEM_LATENCY, 1, cycles from mem_mem_ena assertion to mem_rdata valid; legal range 1..15.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- run_i  in  1  start fetching from HALTED.
- continue_i  in  1  resume from PAUSED; rising edge detected internally.
- pause_i  in  1  decode requests pause; sampled only on handshake cycle.
- redirect_valid_i  in  1  load PC from redirect_pc_i; sampled only on handshake cycle.
- redirect_pc_i  in  ADDR_WIDTH  redirect target.
- ir_valid_o  out  1  IR holds an instruction not yet accepted.
- ir_ready_i  in  1  decode accepts IR.
- ir_o  out  DATA_WIDTH  current instruction.
- ir_pc_o  out  ADDR_WIDTH  address the instruction in IR was fetched from.
- pc_o  out  ADDR_WIDTH  current PC (next fetch address).
- mem_addr  out  ADDR_WIDTH  equals MAR.
- mem_mem_ena  out  1  memory read enable.
- mem_rdata  in  DATA_WIDTH  memory read data.
- state_o  out  3  FSM state encoding, for debug.
- hex_display_debug  out  16  IR zero-extended or truncated to 16 bits.

Behaviour:
- Reset (reset=0 at clk edge):
  - PC=RESET_PC; MAR, MDR, IR, ir_pc_o = 0.
  - ir_valid_o=0, mem_mem_ena=0, latency counter=0, state=HALTED.
  - Reset aborts any in-flight read on the same edge.
- State encoding: HALTED=0, S_MAR=1, S_MEM=2, S_MDR=3, S_IR=4, PAUSED=5.
- HALTED:
  - run_i=1 -> S_MAR.
  - continue_i is ignored; run_i has priority if both are asserted.
- S_MAR: MAR<=PC, ir_pc<=PC, PC<=PC+1 (wraps modulo 2^ADDR_WIDTH); -> S_MEM.
- S_MEM:
  - mem_mem_ena=1 every cycle in this state.
  - Counter counts MEM_LATENCY cycles, then -> S_MDR.
- S_MDR: MDR<=mem_rdata; -> S_IR. mem_mem_ena=0.
- S_IR, entry: IR<=MDR, ir_valid_o=1. ir_valid_o stays high and ir_o stays stable until ir_ready_i=1.
- S_IR, handshake cycle (ir_valid_o & ir_ready_i):
  - ir_valid_o clears on the next edge.
  - If redirect_valid_i=1, PC<=redirect_pc_i, overriding the sequential PC.
  - pause_i=1 -> PAUSED; otherwise -> S_MAR.
  - redirect and pause in the same cycle: both take effect; the redirect is applied before pausing.
- Fetch latency: the first ir_valid_o rises MEM_LATENCY+3 cycles after the S_MAR entry edge. Back-to-back throughput is one instruction per MEM_LATENCY+4 cycles when ir_ready_i=1.
- PAUSED:
  - Rising edge of continue_i (0 in previous cycle, 1 now) -> S_MAR.
  - A continue_i held high through pause entry does not resume.
- redirect_valid_i and pause_i outside the handshake cycle are ignored.
- run_i is ignored outside HALTED.
- IR, MDR and PC hold their values in PAUSED and HALTED.

Optional Feature:
- Macro: FETCH_BREAKPOINT_EN.
- When defined:
  - Adds ports bp_en_i (in, 1), bp_addr_i (in, ADDR_WIDTH) and bp_hit_o (out, 1).
  - In S_MAR, if bp_en_i=1 and PC==bp_addr_i, the FSM goes to PAUSED instead of S_MEM. PC and MAR are not modified and bp_hit_o is pulsed for one cycle.
  - The fetch at bp_addr_i proceeds normally after the next continue_i rising edge. The breakpoint is not retaken on the S_MAR immediately following that resume.
- When undefined: the ports are absent and S_MAR always -> S_MEM.

Test Plan:
- Reset then run_i pulse, MEM_LATENCY=1, memory[0]=16'h1234, ir_ready_i=1 -> ir_valid_o high 4 cycles after S_MAR entry; ir_o=16'h1234, ir_pc_o=0, pc_o=1.
- MEM_LATENCY=3, ir_ready_i held 0 for 5 cycles -> ir_valid_o and ir_o stable for all 5 cycles; no mem_mem_ena pulses while waiting.
- Handshake at ir_pc_o=16'h0004 with redirect_valid_i=1, redirect_pc_i=16'h3000 -> next mem_addr=16'h3000 and next ir_pc_o=16'h3000.
- Handshake with pause_i=1 -> state_o=5. continue_i held 1 across pause entry does not resume; a 0->1 continue_i edge resumes with mem_addr=the next PC.
- PC=16'hFFFF fetch -> pc_o wraps to 16'h0000. Reset asserted during S_MEM -> mem_mem_ena=0 and state_o=0 on the next edge, pc_o=RESET_PC.
- With FETCH_BREAKPOINT_EN, bp_addr_i=16'h0002 -> PAUSED with mem_addr≠2 and one bp_hit_o pulse. After continue_i rises, the instruction from address 2 is delivered.

Source files
------------

// File: rtl/fetch_unit.sv
// SLC-3 instruction fetch engine: PC/MAR/MDR/IR sequencing against latency-configurable memory.
// Optional breakpoint support is enabled with `define FETCH_BREAKPOINT_EN.
module fetch_unit #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned RESET_PC    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run_i,
    input  logic                  continue_i,
    input  logic                  pause_i,
    input  logic                  redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  ir_valid_o,
    input  logic                  ir_ready_i,
    output logic [DATA_WIDTH-1:0] ir_o,
    output logic [ADDR_WIDTH-1:0] ir_pc_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_mem_ena,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [2:0]            state_o,
    output logic [15:0]           hex_display_debug
`ifdef FETCH_BREAKPOINT_EN
    ,
    input  logic                  bp_en_i,
    input  logic [ADDR_WIDTH-1:0] bp_addr_i,
    output logic                  bp_hit_o
`endif
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [2:0] {
        HALTED = 3'd0,
        S_MAR  = 3'd1,
        S_MEM  = 3'd2,
        S_MDR  = 3'd3,
        S_IR   = 3'd4,
        PAUSED = 3'd5
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [CNT_W-1:0]        lat_cnt_q;
    logic [DATA_WIDTH-1:0]   mdr_q;
    logic                    cont_q;
    logic                    handshake_c;
    logic                    cont_rise_c;
    logic                    bp_take_c;

    assign handshake_c = (state_q == S_IR) && ir_valid_o && ir_ready_i;
    assign cont_rise_c = continue_i && !cont_q;

`ifdef FETCH_BREAKPOINT_EN
    // Skip flag lets the resumed fetch at the breakpoint address go through once.
    logic bp_skip_q;
    assign bp_take_c = (state_q == S_MAR) && bp_en_i && (pc_o == bp_addr_i) && !bp_skip_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            bp_skip_q <= 1'b0;
            bp_hit_o  <= 1'b0;
        end else begin
            bp_hit_o <= bp_take_c;
            if (bp_take_c) begin
                bp_skip_q <= 1'b1;
            end else if (state_q == S_MAR) begin
                bp_skip_q <= 1'b0;
            end
        end
    end
`else
    assign bp_take_c = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HALTED:  if (run_i) state_d = S_MAR;
            S_MAR:   state_d = bp_take_c ? PAUSED : S_MEM;
            S_MEM:   if (lat_cnt_q == LAT_LAST) state_d = S_MDR;
            S_MDR:   state_d = S_IR;
            S_IR:    if (handshake_c) state_d = pause_i ? PAUSED : S_MAR;
            PAUSED:  if (cont_rise_c) state_d = S_MAR;
            default: state_d = HALTED;
        endcase
    end

    // State register and fetch datapath.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= HALTED;
            lat_cnt_q   <= '0;
            mdr_q       <= '0;
            cont_q      <= 1'b0;
            pc_o        <= ADDR_WIDTH'(RESET_PC);
            mem_addr    <= '0;
            ir_pc_o     <= '0;
            ir_o        <= '0;
            ir_valid_o  <= 1'b0;
            mem_mem_ena <= 1'b0;
        end else begin
            state_q     <= state_d;
            cont_q      <= continue_i;
            mem_mem_ena <= (state_d == S_MEM);
            case (state_q)
                S_MAR: begin
                    if (!bp_take_c) begin
                        mem_addr <= pc_o;
                        ir_pc_o  <= pc_o;
                        pc_o     <= pc_o + ADDR_WIDTH'(1);
                    end
                end
                S_MEM: begin
                    lat_cnt_q <= (lat_cnt_q == LAT_LAST) ? '0 : lat_cnt_q + CNT_W'(1);
                end
                S_MDR: mdr_q <= mem_rdata;
                S_IR: begin
                    // First S_IR cycle loads IR; later cycles wait for decode to accept it.
                    if (!ir_valid_o) begin
                        ir_o       <= mdr_q;
                        ir_valid_o <= 1'b1;
                    end else if (ir_ready_i) begin
                        ir_valid_o <= 1'b0;
                        if (redirect_valid_i) pc_o <= redirect_pc_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state_o           = state_q;
    assign hex_display_debug = 16'(ir_o);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: transaction-level model of fetch address, data and timing.
module tb_fetch_unit;

    localparam int unsigned LAT    = 3;
    localparam int unsigned RST_PC = 0;

    logic        clk;
    logic        reset;
    logic        run_i;
    logic        continue_i;
    logic        pause_i;
    logic        redirect_valid_i;
    logic [15:0] redirect_pc_i;
    logic        ir_valid_o;
    logic        ir_ready_i;
    logic [15:0] ir_o;
    logic [15:0] ir_pc_o;
    logic [15:0] pc_o;
    logic [15:0] mem_addr;
    logic        mem_mem_ena;
    logic [15:0] mem_rdata;
    logic [2:0]  state_o;
    logic [15:0] hex_display_debug;
`ifdef FETCH_BREAKPOINT_EN
    logic        bp_en_i;
    logic [15:0] bp_addr_i;
    logic        bp_hit_o;
`endif

    fetch_unit #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (16),
        .MEM_LATENCY(LAT),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .run_i            (run_i),
        .continue_i       (continue_i),
        .pause_i          (pause_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .ir_valid_o       (ir_valid_o),
        .ir_ready_i       (ir_ready_i),
        .ir_o             (ir_o),
        .ir_pc_o          (ir_pc_o),
        .pc_o             (pc_o),
        .mem_addr         (mem_addr),
        .mem_mem_ena      (mem_mem_ena),
        .mem_rdata        (mem_rdata),
        .state_o          (state_o),
        .hex_display_debug(hex_display_debug)
`ifdef FETCH_BREAKPOINT_EN
        ,
        .bp_en_i          (bp_en_i),
        .bp_addr_i        (bp_addr_i),
        .bp_hit_o         (bp_hit_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory with LAT-cycle read pipeline advancing while enabled.
    logic [15:0] mem  [0:65535];
    logic [15:0] pipe [0:LAT-1];
    assign mem_rdata = pipe[LAT-1];
    always @(posedge clk) begin
        if (mem_mem_ena) begin
            pipe[0] <= mem[mem_addr];
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    int n_vec;
    int n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_noise();
        run_i            = 1'b0;
        pause_i          = 1'b0;
        redirect_valid_i = 1'b0;
        ir_ready_i       = 1'b0;
    endtask

    // Called just after the edge that launched a fetch; waits for IR valid with noise on inputs.
    task automatic wait_fetch(input logic [15:0] addr);
        int n;
        int ena;
        n   = 0;
        ena = 0;
        while (!ir_valid_o && n < 60) begin
            ir_ready_i       = 1'($urandom_range(0, 1));
            redirect_valid_i = 1'($urandom_range(0, 1));
            pause_i          = 1'($urandom_range(0, 1));
            run_i            = 1'($urandom_range(0, 1));
            redirect_pc_i    = 16'($urandom);
            tick();
            n++;
            if (mem_mem_ena) begin
                ena++;
                check("mem_addr", 32'(mem_addr), 32'(addr));
            end
        end
        clear_noise();
        check("latency", 32'(n), 32'(LAT + 3));
        check("ena_cycles", 32'(ena), 32'(LAT));
        check("ir", 32'(ir_o), 32'(mem[addr]));
        check("hex", 32'(hex_display_debug), 32'(mem[addr]));
        check("ir_pc", 32'(ir_pc_o), 32'(addr));
        check("pc", 32'(pc_o), 32'(16'(addr + 16'd1)));
    endtask

    task automatic hold_ir(input int k, input logic [15:0] addr);
        for (int j = 0; j < k; j++) begin
            ir_ready_i       = 1'b0;
            pause_i          = 1'($urandom_range(0, 1));
            redirect_valid_i = 1'($urandom_range(0, 1));
            tick();
            check("hold_valid", 32'(ir_valid_o), 32'd1);
            check("hold_ir", 32'(ir_o), 32'(mem[addr]));
            check("hold_ena", 32'(mem_mem_ena), 32'd0);
        end
        clear_noise();
    endtask

    task automatic handshake(input bit redir, input logic [15:0] rpc, input bit pse, input bit hold_cont);
        ir_ready_i       = 1'b1;
        redirect_valid_i = redir;
        redirect_pc_i    = rpc;
        pause_i          = pse;
        continue_i       = hold_cont;
        tick();
        clear_noise();
        check("valid_clear", 32'(ir_valid_o), 32'd0);
        check("hs_state", 32'(state_o), pse ? 32'd5 : 32'd1);
    endtask

    initial begin
        logic [15:0] addr;
        logic [15:0] nxt;
        logic [15:0] rpc;
        bit          redir;
        bit          pse;
        bit          hold;

        n_vec = 0;
        n_err = 0;
        for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
        mem[0] = 16'h1234;
        for (int i = 0; i < LAT; i++) pipe[i] = '0;
        clear_noise();
        continue_i    = 1'b0;
        redirect_pc_i = '0;
`ifdef FETCH_BREAKPOINT_EN
        bp_en_i   = 1'b0;
        bp_addr_i = '0;
`endif

        reset = 1'b0;
        tick();
        tick();
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_pc", 32'(pc_o), 32'(RST_PC));
        check("rst_valid", 32'(ir_valid_o), 32'd0);
        check("rst_ena", 32'(mem_mem_ena), 32'd0);
        check("rst_ir", 32'(ir_o), 32'd0);
        check("rst_mar", 32'(mem_addr), 32'd0);
        reset = 1'b1;

        // continue_i has no effect while halted.
        continue_i = 1'b1;
        tick();
        continue_i = 1'b0;
        tick();
        check("halt_cont_state", 32'(state_o), 32'd0);
        check("halt_cont_ena", 32'(mem_mem_ena), 32'd0);

        run_i = 1'b1;
        tick();
        run_i = 1'b0;
        addr  = 16'(RST_PC);

        for (int i = 0; i < 40; i++) begin
            wait_fetch(addr);
            hold_ir((i == 0) ? 5 : $urandom_range(0, 4), addr);
            rpc   = 16'($urandom);
            redir = ($urandom_range(0, 3) == 0);
            pse   = ($urandom_range(0, 3) == 0);
            if (i < 4 || i == 5 || i == 7) begin
                redir = 1'b0;
                pse   = 1'b0;
            end
            if (i == 2 || i == 3) pse = 1'b1;
            if (i == 4) begin
                redir = 1'b1;
                rpc   = 16'h3000;
            end
            if (i == 6) begin
                redir = 1'b1;
                rpc   = 16'hFFFF;
            end
            hold = pse && ((i == 2) || ($urandom_range(0, 1) == 1));
            nxt  = redir ? rpc : 16'(addr + 16'd1);
            handshake(redir, rpc, pse, hold);
            if (pse) begin
                for (int j = 0; j < 3; j++) begin
                    tick();
                    check("paused_state", 32'(state_o), 32'd5);
                    check("paused_ena", 32'(mem_mem_ena), 32'd0);
                end
                continue_i = 1'b0;
                tick();
                check("paused_pc", 32'(pc_o), 32'(nxt));
                check("paused_ir", 32'(ir_o), 32'(mem[addr]));
                continue_i = 1'b1;
                tick();
                continue_i = 1'b0;
            end
            addr = nxt;
        end

        // Reset while the read is in flight.
        tick();
        check("inflight_ena", 32'(mem_mem_ena), 32'd1);
        reset = 1'b0;
        tick();
        check("abort_ena", 32'(mem_mem_ena), 32'd0);
        check("abort_state", 32'(state_o), 32'd0);
        check("abort_pc", 32'(pc_o), 32'(RST_PC));
        reset = 1'b1;
        tick();
        check("post_rst_state", 32'(state_o), 32'd0);

`ifdef FETCH_BREAKPOINT_EN
        bp_en_i   = 1'b1;
        bp_addr_i = 16'h0002;
        run_i     = 1'b1;
        tick();
        run_i = 1'b0;
        wait_fetch(16'h0000);
        handshake(1'b0, 16'h0, 1'b0, 1'b0);
        wait_fetch(16'h0001);
        handshake(1'b0, 16'h0, 1'b0, 1'b0);
        tick();
        check("bp_state", 32'(state_o), 32'd5);
        check("bp_hit", 32'(bp_hit_o), 32'd1);
        check("bp_mar", 32'(mem_addr), 32'h0001);
        check("bp_pc", 32'(pc_o), 32'h0002);
        tick();
        check("bp_hit_pulse", 32'(bp_hit_o), 32'd0);
        check("bp_still_paused", 32'(state_o), 32'd5);
        continue_i = 1'b1;
        tick();
        continue_i = 1'b0;
        wait_fetch(16'h0002);
        handshake(1'b0, 16'h0, 1'b0, 1'b0);
        wait_fetch(16'h0003);
        bp_en_i = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
